// File: rtl/frame_commit_pkg.sv
// frame_commit_pkg
// Shared definitions for the frame-synchronous register commit controller:
// the commit state machine encoding, the control-register offsets (relative
// to NUM_REGS) and the bit positions used inside the CTRL/IRQ_CLR registers.
package frame_commit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Word offsets of the control registers, added to NUM_REGS.
    localparam int CTRL_OFS      = 0;
    localparam int IRQ_CLR_OFS   = 1;
    localparam int FRAME_CNT_OFS = 2;

    // CTRL write fields.
    localparam int CTRL_ARM_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // IRQ_CLR write field.
    localparam int IRQ_CLR_BIT = 0;

    // CTRL read fields; the frame count fills everything above FCNT_LSB.
    localparam int CTRL_RD_PENDING  = 0;
    localparam int CTRL_RD_IRQ_EN   = 1;
    localparam int CTRL_RD_IRQ_FLAG = 2;
    localparam int CTRL_RD_FCNT_LSB = 3;

endpackage

// File: rtl/frame_commit_ctrl_vblank_sync.sv
// vblank_sync
// Brings the asynchronous vga_vblank level into the clk domain through two
// synchronizer flops and produces a registered one-cycle rising-edge pulse.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   vblank_in     - raw vertical-blank level from the VGA timing generator
//   vblank_rise   - one-cycle pulse, 3 clocks after vblank_in rises
module vblank_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic vblank_in,
    output logic vblank_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;

    always_comb begin
        sync1_d = vblank_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign vblank_rise = rise_q;

endmodule

// File: rtl/frame_commit_ctrl.sv
// frame_commit_ctrl
// Avalon-MM slave holding NUM_REGS shadow registers that software writes at
// any time. An armed commit copies the whole shadow set into the active set
// at the start of the next vertical blank, so the renderer always sees a
// consistent frame. Also counts frames and raises a per-frame interrupt.
// Ports:
//   clk, reset_n                   - clock, asynchronous active-low reset
//   chipselect/write/read/address/writedata/readdata - Avalon-MM slave,
//                                    readdata registered (latency 1)
//   vga_vblank                     - vertical-blank level (asynchronous)
//   active_regs                    - active set, reg i at [i*DATA_W +: DATA_W]
//   commit_pulse                   - high for the cycle the active set updates
//   irq                            - irq_flag & irq_en
module frame_commit_ctrl
    import frame_commit_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          readdata,
    input  logic                       vga_vblank,
    output logic [NUM_REGS*DATA_W-1:0] active_regs,
    output logic                       commit_pulse,
    output logic                       irq
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] NREGS_ADDR     = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR      = ADDR_W'(NUM_REGS + CTRL_OFS);
    localparam logic [ADDR_W-1:0] IRQ_CLR_ADDR   = ADDR_W'(NUM_REGS + IRQ_CLR_OFS);
    localparam logic [ADDR_W-1:0] FRAME_CNT_ADDR = ADDR_W'(NUM_REGS + FRAME_CNT_OFS);

    logic vblank_rise;

    vblank_sync u_vblank_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .vblank_in   (vga_vblank),
        .vblank_rise (vblank_rise)
    );

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   shadow_d [NUM_REGS];
    logic [DATA_W-1:0]   active_q [NUM_REGS];
    logic [DATA_W-1:0]   active_d [NUM_REGS];
    logic                defer_vld_q, defer_vld_d;
    logic [IDX_W-1:0]    defer_idx_q, defer_idx_d;
    logic [DATA_W-1:0]   defer_data_q, defer_data_d;
    logic                irq_en_q, irq_en_d;
    logic                irq_flag_q, irq_flag_d;
    logic [DATA_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]   readdata_q, readdata_d;

    logic                wr_en, rd_en, is_shadow, shadow_wr;
    logic                ctrl_wr, arm_wr, clr_wr;
    logic [IDX_W-1:0]    reg_idx;
    logic                pending, commit_start;
    logic [DATA_W-1:0]   shadow_rd, ctrl_rd;

    // Bus decode
    always_comb begin
        wr_en     = chipselect & write;
        rd_en     = chipselect & read;
        is_shadow = (address < NREGS_ADDR);
        reg_idx   = address[IDX_W-1:0];
        shadow_wr = wr_en & is_shadow;
        ctrl_wr   = wr_en & (address == CTRL_ADDR);
        arm_wr    = ctrl_wr & writedata[CTRL_ARM_BIT];
        clr_wr    = wr_en & (address == IRQ_CLR_ADDR) & writedata[IRQ_CLR_BIT];
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm_wr)      state_d = ARMED;
            ARMED:   if (vblank_rise) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        pending      = (state_q != IDLE);
        commit_pulse = (state_q == COMMIT);
        commit_start = (state_q == ARMED) & vblank_rise;
    end

    // A shadow write landing on the cycle that starts a commit must not leak
    // into that commit, yet COMMIT copies shadow_q one cycle later. The write
    // is parked in a one-entry buffer and lands in shadow at the COMMIT edge,
    // after the copy has sampled the old contents.
    always_comb begin
        shadow_d     = shadow_q;
        defer_vld_d  = 1'b0;
        defer_idx_d  = defer_idx_q;
        defer_data_d = defer_data_q;
        if (defer_vld_q) begin
            shadow_d[defer_idx_q] = defer_data_q;
        end
        if (shadow_wr) begin
            if (commit_start) begin
                defer_vld_d  = 1'b1;
                defer_idx_d  = reg_idx;
                defer_data_d = writedata;
            end else begin
                shadow_d[reg_idx] = writedata;
            end
        end
    end

    always_comb begin
        active_d = active_q;
        if (commit_pulse) begin
            active_d = shadow_q;
        end
    end

    // Frame counter and interrupt; a vblank edge beats a coincident clear.
    always_comb begin
        frame_cnt_d = vblank_rise ? frame_cnt_q + 1'b1 : frame_cnt_q;
        irq_en_d    = ctrl_wr ? writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
        if (vblank_rise) begin
            irq_flag_d = 1'b1;
        end else if (clr_wr) begin
            irq_flag_d = 1'b0;
        end else begin
            irq_flag_d = irq_flag_q;
        end
    end

    // Read mux; a parked write is forwarded so software reads what it wrote.
    always_comb begin
        shadow_rd = shadow_q[reg_idx];
        if (defer_vld_q && (defer_idx_q == reg_idx)) begin
            shadow_rd = defer_data_q;
        end
        ctrl_rd                                  = '0;
        ctrl_rd[CTRL_RD_PENDING]                 = pending;
        ctrl_rd[CTRL_RD_IRQ_EN]                  = irq_en_q;
        ctrl_rd[CTRL_RD_IRQ_FLAG]                = irq_flag_q;
        ctrl_rd[DATA_W-1:CTRL_RD_FCNT_LSB]       = frame_cnt_q[DATA_W-1-CTRL_RD_FCNT_LSB:0];

        readdata_d = readdata_q;
        if (rd_en) begin
            if (is_shadow) begin
                readdata_d = shadow_rd;
            end else if (address == CTRL_ADDR) begin
                readdata_d = ctrl_rd;
            end else if (address == FRAME_CNT_ADDR) begin
                readdata_d = frame_cnt_q;
            end else begin
                readdata_d = '0;
            end
        end
    end

    // FSM: state register, plus all other storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            defer_vld_q  <= 1'b0;
            defer_idx_q  <= '0;
            defer_data_q <= '0;
            irq_en_q     <= 1'b0;
            irq_flag_q   <= 1'b0;
            frame_cnt_q  <= '0;
            readdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            defer_vld_q  <= defer_vld_d;
            defer_idx_q  <= defer_idx_d;
            defer_data_q <= defer_data_d;
            irq_en_q     <= irq_en_d;
            irq_flag_q   <= irq_flag_d;
            frame_cnt_q  <= frame_cnt_d;
            readdata_q   <= readdata_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_active
        assign active_regs[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign readdata = readdata_q;
    assign irq      = irq_flag_q & irq_en_q;

endmodule
